sram_arbiter_2_1: RTL



---
 rtl/sram_arbiter_2_1_pkg.sv | 26 ++
 rtl/sram_arbiter_2_1_if.sv | 29 ++
 rtl/sram_arbiter_2_1_owner_fifo.sv | 66 ++++++
 rtl/sram_arbiter_2_1.sv | 131 +++++++++++++
 4 files changed

// File: rtl/sram_arbiter_2_1_pkg.sv
// ============================================================================
// Module  : sram_arbiter_2_1_pkg
// Brief   : Shared owner/state encodings for the 2:1 SRAM arbiter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package sram_arbiter_2_1_pkg;

  typedef enum logic {
    OWNER_INST = 1'b0,
    OWNER_DATA = 1'b1
  } owner_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_LOCK = 1'b1
  } state_e;

  function automatic owner_e other_owner(input owner_e o);
    return (o == OWNER_INST) ? OWNER_DATA : OWNER_INST;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sram_arbiter_2_1_if.sv
// ============================================================================
// Module  : sram_arbiter_2_1_if
// Brief   : SRAM-like request/response bus with master and slave views.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface sram_arbiter_2_1_if;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        addr_ok;
  logic        data_ok;

  modport master (
    output req, wr, size, addr, wdata,
    input  rdata, addr_ok, data_ok
  );

  modport slave (
    input  req, wr, size, addr, wdata,
    output rdata, addr_ok, data_ok
  );
endinterface

`default_nettype wire

// File: rtl/sram_arbiter_2_1_owner_fifo.sv
// ============================================================================
// Module  : owner_fifo
// Brief   : Synchronous 1-bit-wide FIFO recording the owner of each accepted
//           transaction; asynchronous active-low clear.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module owner_fifo #(
  parameter int DEPTH = 2
) (
  input  wire logic clk,
  input  wire logic resetn,
  input  wire logic push,
  input  wire logic pop,
  input  wire logic din,
  output logic      dout,
  output logic      full,
  output logic      empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [DEPTH-1:0] r_mem;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push_en;
  logic             w_pop_en;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full      = (r_count == CNT_W'(DEPTH));
  assign empty     = (r_count == '0);
  assign w_push_en = push & ~full;
  assign w_pop_en  = pop & ~empty;
  assign dout      = r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_push_en) begin
      r_mem[r_wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_en) r_wr_ptr <= next_ptr(r_wr_ptr);
      if (w_pop_en)  r_rd_ptr <= next_ptr(r_rd_ptr);
      case ({w_push_en, w_pop_en})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/sram_arbiter_2_1.sv
// ============================================================================
// Module  : sram_arbiter_2_1
// Brief   : Arbitrates inst/data SRAM masters onto one slave port, locking the
//           grant while a request waits and routing in-order responses back.
//           Define ARB_ROUND_ROBIN_EN for round-robin instead of data>inst.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module sram_arbiter_2_1
  import sram_arbiter_2_1_pkg::*;
#(
  parameter int OUTSTANDING = 2
) (
  input  wire logic         clk,
  input  wire logic         resetn,
  sram_arbiter_2_1_if.slave  inst,
  sram_arbiter_2_1_if.slave  data,
  sram_arbiter_2_1_if.master wrap
);

  state_e r_state;
  state_e w_state_nxt;
  owner_e r_grant;
  owner_e w_grant_nxt;
  owner_e w_arb_pick;
  owner_e w_owner;
  logic   w_owner_req;
  logic   w_wrap_req;
  logic   w_push;
  logic   w_pop;
  logic   w_fifo_full;
  logic   w_fifo_empty;
  logic   w_head;
  logic   w_inst_dok;
  logic   w_data_dok;

`ifdef ARB_ROUND_ROBIN_EN
  owner_e r_last;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_last <= OWNER_INST;
    end else if (w_push) begin
      r_last <= w_owner;
    end
  end
`endif

  always_comb begin
    w_arb_pick = OWNER_INST;
    if (inst.req && data.req) begin
`ifdef ARB_ROUND_ROBIN_EN
      w_arb_pick = other_owner(r_last);
`else
      w_arb_pick = OWNER_DATA;
`endif
    end else if (data.req) begin
      w_arb_pick = OWNER_DATA;
    end
  end

  // Once a request has been presented but not accepted, the owner is frozen.
  assign w_owner     = (r_state == ST_LOCK) ? r_grant : w_arb_pick;
  assign w_owner_req = (w_owner == OWNER_DATA) ? data.req : inst.req;
  assign w_wrap_req  = w_owner_req & ~w_fifo_full;
  assign w_push      = w_wrap_req & wrap.addr_ok;
  assign w_pop       = wrap.data_ok & ~w_fifo_empty;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= ST_IDLE;
      r_grant <= OWNER_INST;
    end else begin
      r_state <= w_state_nxt;
      r_grant <= w_grant_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    case (r_state)
      ST_IDLE: begin
        if (!w_push && w_wrap_req) begin
          w_state_nxt = ST_LOCK;
          w_grant_nxt = w_owner;
        end
      end
      ST_LOCK: begin
        // A dropped request abandons the lock without pushing anything.
        if (w_push || !w_owner_req) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  owner_fifo #(
    .DEPTH (OUTSTANDING)
  ) u_owner_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (w_push),
    .pop    (w_pop),
    .din    (w_owner == OWNER_DATA),
    .dout   (w_head),
    .full   (w_fifo_full),
    .empty  (w_fifo_empty)
  );

  assign wrap.req   = w_wrap_req;
  assign wrap.wr    = (w_owner == OWNER_DATA) ? data.wr    : inst.wr;
  assign wrap.size  = (w_owner == OWNER_DATA) ? data.size  : inst.size;
  assign wrap.addr  = (w_owner == OWNER_DATA) ? data.addr  : inst.addr;
  assign wrap.wdata = (w_owner == OWNER_DATA) ? data.wdata : inst.wdata;

  assign inst.addr_ok = w_push & (w_owner == OWNER_INST);
  assign data.addr_ok = w_push & (w_owner == OWNER_DATA);

  assign w_inst_dok   = w_pop & ~w_head;
  assign w_data_dok   = w_pop & w_head;
  assign inst.data_ok = w_inst_dok;
  assign data.data_ok = w_data_dok;
  assign inst.rdata   = w_inst_dok ? wrap.rdata : 32'd0;
  assign data.rdata   = w_data_dok ? wrap.rdata : 32'd0;

endmodule

`default_nettype wire
